grad_mag_orient: RTL
====================

Name: grad_mag_orient

Overview:
- Downstream consumer of the x/y gradient stage. It streams the signed x-gradient and y-gradient BRAMs for one WIDTH*HEIGHT image.
- For every pixel it computes a saturated magnitude and a 3-bit orientation octant, then writes both into output BRAMs at the same address.
- The output feeds the SIFT orientation-histogram stage.
- Pipelined: one pixel per cycle after a 3-cycle fill.

Parameters:
- WIDTH, 64, image width in pixels
- HEIGHT, 64, image height in pixels
- BIT_DEPTH, 8, unsigned pixel depth; gradients are BIT_DEPTH+1 bits, two's complement

Ports:
- clk_in  input  1  clock
- rst_n_in  input  1  asynchronous active-low reset
- start_in  input  1  one-cycle pulse; begins a pass when idle
- busy_out  output  1  high from the cycle after an accepted start until done_out
- done_out  output  1  one-cycle pulse at end of pass
- grad_read_addr  output  $clog2(WIDTH*HEIGHT)  shared read address to the x and y gradient BRAMs
- grad_read_valid  output  1  read strobe, high when address is issued
- x_grad_in  input  BIT_DEPTH+1  signed x gradient, valid 2 cycles after address
- y_grad_in  input  BIT_DEPTH+1  signed y gradient, valid 2 cycles after address
- out_write_addr  output  $clog2(WIDTH*HEIGHT)  write address, shared by the magnitude and bin BRAMs
- out_write_valid  output  1  write strobe for both output BRAMs
- mag_out  output  BIT_DEPTH  unsigned saturated magnitude
- bin_out  output  3  orientation octant 0..7

Behaviour:
- Reset (async, rst_n_in=0): all outputs are 0, state is IDLE, and the address counter is 0. Pipeline valid bits are cleared, so no write strobe occurs after reset even mid-pass.
- States:
  - IDLE: on start_in go to ISSUE, addr counter <= 0, busy_out <= 1.
  - ISSUE: each cycle present grad_read_addr=counter with grad_read_valid=1, then increment the counter. After issuing address N-1 (N=WIDTH*HEIGHT), go to DRAIN.
  - DRAIN: wait until the last write strobe has been issued, then done_out=1 for 1 cycle, busy_out <= 0, go to IDLE.
- start_in while busy_out=1 is ignored.
- Pipeline:
  - Address issued at cycle t; gradient data are sampled at t+2.
  - Magnitude and bin are registered, and out_write_valid/out_write_addr/mag_out/bin_out appear at t+3. out_write_addr equals the address issued at t.
  - Read-valid is delayed via a 3-deep shift register; the issued address travels alongside it.
- Throughput 1 pixel/cycle; no gaps in grad_read_valid during ISSUE.
- done_out is asserted the cycle after the final write strobe (address N-1).
- Start-to-done is N+4 cycles, measured from the start_in sample edge to the done_out cycle.
- Arithmetic:
  - ax=|x_grad_in|, ay=|y_grad_in|, both BIT_DEPTH+1 bits unsigned; |-2^BIT_DEPTH| = 2^BIT_DEPTH, no overflow.
  - Default magnitude is ax+ay, computed in BIT_DEPTH+2 bits and saturated to 2^BIT_DEPTH-1.
- Orientation bin (octant k covers [45k°, 45(k+1)°) of atan2(gy,gx)):
  - gx>0, gy>=0: ay<ax ? 0 : 1
  - gx<=0, gy>0: ax<ay ? 2 : 3
  - gx<0, gy<=0: ay<ax ? 4 : 5
  - gx>=0, gy<0: ax<ay ? 6 : 7
  - gx=0 and gy=0: bin 0, mag 0
- Address counter wrap: the counter stops at N-1 and is not wrapped; it is reinitialised on the next start.
- Write strobes are single-cycle per pixel; the strobe is never held between pixels.

Optional Feature:
- Macro: GRAD_MAG_L2_APPROX_EN.
- Defined: magnitude = max(ax,ay) + (min(ax,ay)>>1), a floor-based L2 approximation, saturated to 2^BIT_DEPTH-1. Pipeline latency is unchanged.
- Undefined: L1 magnitude ax+ay, saturated. Bin logic is identical in both builds.

Test Plan:
- Sequencing (WIDTH=HEIGHT=4, BRAM model with 2-cycle latency): start pulse -> 16 consecutive grad_read_valid cycles with addresses 0..15. Writes follow at addresses 0..15, each exactly 3 cycles after its read. done_out fires once, 20 cycles after start; busy_out drops in the same cycle.
- Bin boundaries: (gx,gy) = (10,0)->0, (10,10)->1, (0,10)->2, (-10,10)->3, (-10,0)->4, (-10,-10)->5, (0,-10)->6, (10,-10)->7, (0,0)->bin 0 mag 0.
- Magnitude:
  - L1: (30,40)->70; (-200,100)->255 saturated, bin 3; (-256,-256)->255, bin 5.
  - With GRAD_MAG_L2_APPROX_EN: (30,40)->55; (-200,100)->250; (0,-256)->255.
- Start ignored mid-pass: extra start_in at cycle 5 of a pass -> address sequence is unbroken, exactly one done_out, and no second pass.
- Reset mid-pass: rst_n_in low for 1 cycle at cycle 8 -> outputs are 0 immediately (asynchronous). No out_write_valid occurs afterwards until a new start. A new start then runs a full clean pass from address 0.

Source files
------------

// File: rtl/grad_mag_orient.sv
// Gradient magnitude and orientation-octant stage: streams x/y gradient BRAMs, writes mag/bin BRAMs.
// Define GRAD_MAG_L2_APPROX_EN to use max+min/2 magnitude instead of the default L1 |gx|+|gy|.
module grad_mag_orient #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned HEIGHT    = 64,
  parameter int unsigned BIT_DEPTH = 8
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              start_in,
  output logic                              busy_out,
  output logic                              done_out,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]   grad_read_addr,
  output logic                              grad_read_valid,
  input  logic [BIT_DEPTH:0]                x_grad_in,
  input  logic [BIT_DEPTH:0]                y_grad_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]   out_write_addr,
  output logic                              out_write_valid,
  output logic [BIT_DEPTH-1:0]              mag_out,
  output logic [2:0]                        bin_out
);

  localparam int unsigned N  = WIDTH * HEIGHT;
  localparam int unsigned AW = $clog2(N);
  localparam int unsigned GW = BIT_DEPTH + 1;
  localparam logic [AW-1:0] LastAddr = AW'(N - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Read strobe and address travel together through a 3-deep delay line
  logic [2:0]      vld_q;
  logic [AW-1:0]   addr1_q, addr2_q, addr3_q;
  logic [BIT_DEPTH-1:0] mag_q;
  logic [2:0]      bin_q;

  logic [GW-1:0]   ax, ay;
  logic [GW:0]     sum_raw;
  logic [BIT_DEPTH-1:0] mag_sat;
  logic [2:0]      bin_d;
  logic            x_neg, y_neg, x_zero, y_zero, x_pos, y_pos;

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_in) begin
          state_d = StIssue;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      StIssue: begin
        if (cnt_q == LastAddr) begin
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      StDrain: begin
        if (vld_q[2] && (addr3_q == LastAddr)) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    grad_read_valid = (state_q == StIssue);
    grad_read_addr  = cnt_q;
    busy_out        = busy_q;
    done_out        = done_q;
    out_write_valid = vld_q[2];
    out_write_addr  = addr3_q;
    mag_out         = mag_q;
    bin_out         = bin_q;
  end

  // Magnitude: absolute values fit in GW bits, even for -2^BIT_DEPTH
  always_comb begin
    ax = x_grad_in[GW-1] ? (~x_grad_in + GW'(1)) : x_grad_in;
    ay = y_grad_in[GW-1] ? (~y_grad_in + GW'(1)) : y_grad_in;
`ifdef GRAD_MAG_L2_APPROX_EN
    if (ax >= ay) begin
      sum_raw = {1'b0, ax} + ({1'b0, ay} >> 1);
    end else begin
      sum_raw = {1'b0, ay} + ({1'b0, ax} >> 1);
    end
`else
    sum_raw = {1'b0, ax} + {1'b0, ay};
`endif
    mag_sat = (|sum_raw[GW:BIT_DEPTH]) ? '1 : sum_raw[BIT_DEPTH-1:0];
  end

  // Octant from quadrant plus a |gy| vs |gx| comparison
  always_comb begin
    x_neg  = x_grad_in[GW-1];
    y_neg  = y_grad_in[GW-1];
    x_zero = (x_grad_in == '0);
    y_zero = (y_grad_in == '0);
    x_pos  = !x_neg && !x_zero;
    y_pos  = !y_neg && !y_zero;
    if (x_zero && y_zero) begin
      bin_d = 3'd0;
    end else if (x_pos && !y_neg) begin
      bin_d = (ay < ax) ? 3'd0 : 3'd1;
    end else if (!x_pos && y_pos) begin
      bin_d = (ax < ay) ? 3'd2 : 3'd3;
    end else if (x_neg && !y_pos) begin
      bin_d = (ay < ax) ? 3'd4 : 3'd5;
    end else begin
      bin_d = (ax < ay) ? 3'd6 : 3'd7;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_q   <= '0;
      addr1_q <= '0;
      addr2_q <= '0;
      addr3_q <= '0;
      mag_q   <= '0;
      bin_q   <= '0;
    end else begin
      vld_q   <= {vld_q[1:0], grad_read_valid};
      addr1_q <= grad_read_addr;
      addr2_q <= addr1_q;
      addr3_q <= addr2_q;
      mag_q   <= vld_q[1] ? mag_sat : '0;
      bin_q   <= vld_q[1] ? bin_d : 3'd0;
    end
  end

endmodule
